// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: shares one SPI board-memory command port between N_REQ
// requesters. Round-robin selection, with an optional per-owner lock so a
// multi-command burst (e.g. WREN followed by WRITEs) is never interleaved.
module spi_mem_arbiter #(
    parameter int N_REQ = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_en,
    input  logic [N_REQ-1:0]     req_lock,
    input  logic [2*N_REQ-1:0]   req_cmd,
    input  logic [6*N_REQ-1:0]   req_addr,
    input  logic [2*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_valid,
    output logic [1:0]           req_rdata,
    output logic [N_REQ-1:0]     grant,
    output logic [1:0]           mem_cmd,
    output logic                 mem_en,
    input  logic                 mem_valid,
    output logic [5:0]           mem_addr,
    output logic [1:0]           mem_data,
    input  logic [1:0]           mem_rdata
);

    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_LOCKED
    } state_e;

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    // rr_q holds the index the next round-robin scan starts from.
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic               mem_en_q, mem_en_d;
    logic [1:0]         mem_cmd_q, mem_cmd_d;
    logic [5:0]         mem_addr_q, mem_addr_d;
    logic [1:0]         mem_data_q, mem_data_d;

    // Unpacked views of the packed per-requester command fields.
    logic [1:0] cmd_arr  [N_REQ];
    logic [5:0] addr_arr [N_REQ];
    logic [1:0] data_arr [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign cmd_arr[gi]  = req_cmd[2*gi +: 2];
        assign addr_arr[gi] = req_addr[6*gi +: 6];
        assign data_arr[gi] = req_data[2*gi +: 2];
    end

    // Rotate the request vector so bit 0 corresponds to the scan start.
    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [IDX_W-1:0]   pick_off;
    logic [IDX_W:0]     pick_sum;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    assign req_dbl  = {req_en, req_en} >> rr_q;
    assign req_rot  = req_dbl[N_REQ-1:0];
    assign pick_any = |req_en;

    // Find the first requesting index at or after the round-robin pointer.
    always_comb begin
        pick_off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                pick_off = IDX_W'(k);
            end
        end
        pick_sum = {1'b0, rr_q} + {1'b0, pick_off};
        if (pick_sum >= (IDX_W+1)'(N_REQ)) begin
            pick_sum = pick_sum - (IDX_W+1)'(N_REQ);
        end
        pick_idx = pick_sum[IDX_W-1:0];
    end

    // Next-state logic: ownership, command latching and the mem_en strobe.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        mem_en_d   = mem_en_q;
        mem_cmd_d  = mem_cmd_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;

        case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    grant_d    = N_REQ'(1) << pick_idx;
                    owner_d    = pick_idx;
                    mem_cmd_d  = cmd_arr[pick_idx];
                    mem_addr_d = addr_arr[pick_idx];
                    mem_data_d = data_arr[pick_idx];
                    // Never start a strobe while a stale completion is showing.
                    mem_en_d   = ~mem_valid;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_en_q) begin
                    if (mem_valid) begin
                        mem_en_d = 1'b0;
                        rr_d     = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                        state_d  = S_GAP;
                    end
                end else begin
                    mem_en_d = ~mem_valid;
                end
            end
            S_GAP: begin
                // One cycle for the owner to drop req_en or assert its lock.
                if (req_lock[owner_q]) begin
                    state_d = S_LOCKED;
                end else begin
                    grant_d = '0;
                    state_d = S_IDLE;
                end
            end
            S_LOCKED: begin
                if (req_en[owner_q]) begin
                    mem_cmd_d  = cmd_arr[owner_q];
                    mem_addr_d = addr_arr[owner_q];
                    mem_data_d = data_arr[owner_q];
                    mem_en_d   = ~mem_valid;
                    state_d    = S_ISSUE;
                end else if (!req_lock[owner_q]) begin
                    grant_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                grant_d  = '0;
                mem_en_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_q       <= '0;
            mem_en_q   <= 1'b0;
            mem_cmd_q  <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            mem_en_q   <= mem_en_d;
            mem_cmd_q  <= mem_cmd_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign grant     = grant_q;
    assign mem_en    = mem_en_q;
    assign mem_cmd   = mem_cmd_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign req_valid = grant_q & {N_REQ{mem_valid & mem_en_q}};
    assign req_rdata = mem_rdata;

endmodule
